// File: rtl/memory_controller.sv
// memory_controller
// Bridges the core's load/store unit onto a byte-wide data RAM and the fetch
// stage onto a word-wide program ROM. A load or store becomes a sequence of
// single-byte RAM beats, least significant byte first. Instruction fetches
// run on their own FSM and can overlap data traffic.
module memory_controller #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] DATA_BASE  = 32'hC000_0000,
  parameter int              DATA_BYTES = 65536,
  parameter logic [XLEN-1:0] CODE_BASE  = 32'h8000_0000,
  parameter int              CODE_WORDS = 16384,
  localparam int             RAM_AW     = $clog2(DATA_BYTES),
  localparam int             ROM_AW     = $clog2(CODE_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  // load/store request side
  input  logic              req_read,
  input  logic              req_write,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [1:0]        req_width,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_wdata,
  output logic [XLEN-1:0]   rdata,
  output logic              busy_main,
  output logic              done_main,
  output logic              err_main,
  // instruction fetch side
  input  logic              fetch_req,
  input  logic [XLEN-1:0]   fetch_addr,
  output logic [31:0]       fetch_data,
  output logic              fetch_valid,
  output logic              fetch_err,
  output logic              busy_fetch,
  // data RAM port
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [7:0]        ram_q,
  // program ROM port
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_rden,
  input  logic [31:0]       rom_q
);

  // One past the last legal data offset, and the ROM size in bytes.
  localparam logic [XLEN+1:0] DATA_LIMIT = (XLEN+2)'(DATA_BYTES);
  localparam logic [XLEN:0]   CODE_LIMIT = (XLEN+1)'(4 * CODE_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } main_state_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_WAIT,
    F_DONE
  } fetch_state_t;

  main_state_t  state;
  fetch_state_t fstate;

  // Request decode (combinational, only meaningful while the main FSM is idle)
  logic [2:0]      req_beats;
  logic [1:0]      req_last;
  logic [XLEN:0]   data_off;
  logic [XLEN+1:0] data_end;
  logic            req_err;

  // Access context latched on accept
  logic [1:0]      beat_cnt;
  logic [1:0]      last_beat;
  logic [1:0]      acc_width;
  logic            acc_unsigned;
  logic [XLEN-1:0] wdata_sr;

  // Load return path: ram_q for the beat issued last cycle lands in cap_lane
  logic            cap_en;
  logic [1:0]      cap_lane;
  logic [XLEN-1:0] load_buf;
  logic [XLEN-1:0] merged;
  logic            ext_sign;
  logic [XLEN-1:0] load_result;

  // Fetch decode
  logic [XLEN:0]   code_off;
  logic            fetch_bad;

  // Beat count for the requested width; width 3 yields zero beats and is rejected below.
  always_comb begin
    req_beats = 3'd0;
    case (req_width)
      2'd0:    req_beats = 3'd1;
      2'd1:    req_beats = 3'd2;
      2'd2:    req_beats = 3'd4;
      default: req_beats = 3'd0;
    endcase
    req_last = 2'(req_beats - 3'd1);
  end

  // Range and alignment check; the extra top bits catch addresses below DATA_BASE as huge offsets.
  always_comb begin
    data_off = {1'b0, req_addr} - {1'b0, DATA_BASE};
    data_end = {1'b0, data_off} + (XLEN+2)'(req_beats);
    req_err  = (req_width == 2'd3)
            || (req_read && req_write)
            || ((req_width == 2'd1) && req_addr[0])
            || ((req_width == 2'd2) && (req_addr[1:0] != 2'b00))
            || (data_end > DATA_LIMIT);
  end

  // Fold the final returning byte into the buffer and sign/zero-extend above the top loaded byte.
  always_comb begin
    merged = load_buf;
    if (cap_en) begin
      merged[{cap_lane, 3'b000} +: 8] = ram_q;
    end
    ext_sign    = 1'b0;
    load_result = merged;
    case (acc_width)
      2'd0: begin
        ext_sign    = merged[7] & ~acc_unsigned;
        load_result = {{(XLEN-8){ext_sign}}, merged[7:0]};
      end
      2'd1: begin
        ext_sign    = merged[15] & ~acc_unsigned;
        load_result = {{(XLEN-16){ext_sign}}, merged[15:0]};
      end
      default: load_result = merged;
    endcase
  end

  // ROM window check: word aligned and inside the code region.
  always_comb begin
    code_off  = {1'b0, fetch_addr} - {1'b0, CODE_BASE};
    fetch_bad = (fetch_addr[1:0] != 2'b00) || (code_off >= CODE_LIMIT);
  end

  // Main FSM: accepts a request in IDLE, streams byte beats, then reports completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      beat_cnt     <= 2'd0;
      last_beat    <= 2'd0;
      acc_width    <= 2'd0;
      acc_unsigned <= 1'b0;
      wdata_sr     <= '0;
      cap_en       <= 1'b0;
      cap_lane     <= 2'd0;
      load_buf     <= '0;
      rdata        <= '0;
      busy_main    <= 1'b0;
      done_main    <= 1'b0;
      err_main     <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= 8'd0;
      ram_rden     <= 1'b0;
      ram_wren     <= 1'b0;
    end else begin
      done_main <= 1'b0;
      err_main  <= 1'b0;
      cap_en    <= ram_rden;
      cap_lane  <= beat_cnt;
      if (cap_en) begin
        load_buf[{cap_lane, 3'b000} +: 8] <= ram_q;
      end

      case (state)
        IDLE: begin
          if (req_read || req_write) begin
            if (req_err) begin
              done_main <= 1'b1;
              err_main  <= 1'b1;
            end else begin
              busy_main    <= 1'b1;
              beat_cnt     <= 2'd0;
              last_beat    <= req_last;
              acc_width    <= req_width;
              acc_unsigned <= req_unsigned;
              ram_addr     <= data_off[RAM_AW-1:0];
              if (req_write) begin
                ram_wren  <= 1'b1;
                ram_wdata <= req_wdata[7:0];
                wdata_sr  <= req_wdata >> 8;
                state     <= WR;
              end else begin
                ram_rden <= 1'b1;
                state    <= RD;
              end
            end
          end
        end

        RD: begin
          if (beat_cnt == last_beat) begin
            ram_rden <= 1'b0;
            state    <= DONE;
          end else begin
            beat_cnt <= beat_cnt + 2'd1;
            ram_addr <= ram_addr + RAM_AW'(1);
          end
        end

        WR: begin
          if (beat_cnt == last_beat) begin
            ram_wren  <= 1'b0;
            busy_main <= 1'b0;
            done_main <= 1'b1;
            state     <= IDLE;
          end else begin
            beat_cnt  <= beat_cnt + 2'd1;
            ram_addr  <= ram_addr + RAM_AW'(1);
            ram_wdata <= wdata_sr[7:0];
            wdata_sr  <= wdata_sr >> 8;
          end
        end

        DONE: begin
          rdata     <= load_result;
          busy_main <= 1'b0;
          done_main <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Fetch FSM: one ROM read per request, result registered two cycles after the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fstate      <= F_IDLE;
      rom_addr    <= '0;
      rom_rden    <= 1'b0;
      busy_fetch  <= 1'b0;
      fetch_data  <= 32'd0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;

      case (fstate)
        F_IDLE: begin
          if (fetch_req) begin
            if (fetch_bad) begin
              fetch_valid <= 1'b1;
              fetch_err   <= 1'b1;
            end else begin
              rom_addr   <= code_off[ROM_AW+1:2];
              rom_rden   <= 1'b1;
              busy_fetch <= 1'b1;
              fstate     <= F_WAIT;
            end
          end
        end

        F_WAIT: begin
          rom_rden <= 1'b0;
          fstate   <= F_DONE;
        end

        F_DONE: begin
          fetch_data  <= rom_q;
          fetch_valid <= 1'b1;
          busy_fetch  <= 1'b0;
          fstate      <= F_IDLE;
        end

        default: fstate <= F_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller
// Directed stimulus with a scoreboard: each issued request pushes its expected
// response; negedge monitors pop and compare when done_main / fetch_valid fire.
module tb_memory_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_width;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        busy_main;
  logic        done_main;
  logic        err_main;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        fetch_err;
  logic        busy_fetch;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_rden;
  logic        ram_wren;
  logic [7:0]  ram_q;
  logic [13:0] rom_addr;
  logic        rom_rden;
  logic [31:0] rom_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] last_rdata = 32'd0;
  logic [31:0] last_fetch = 32'd0;
  logic [7:0]  ram_mem [0:65535] = '{default: 8'h00};

  typedef struct {
    int          exp_cyc;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_beats;
    int          exp_busy;
    logic [15:0] exp_addr;
  } main_exp_t;

  typedef struct {
    int          exp_cyc;
    logic [31:0] exp_data;
    bit          exp_err;
    logic [13:0] exp_addr;
  } fetch_exp_t;

  main_exp_t  main_q[$];
  string      main_names[$];
  fetch_exp_t fetch_q[$];
  string      fetch_names[$];

  memory_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_width    (req_width),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rdata        (rdata),
    .busy_main    (busy_main),
    .done_main    (done_main),
    .err_main     (err_main),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_data   (fetch_data),
    .fetch_valid  (fetch_valid),
    .fetch_err    (fetch_err),
    .busy_fetch   (busy_fetch),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rden     (ram_rden),
    .ram_wren     (ram_wren),
    .ram_q        (ram_q),
    .rom_addr     (rom_addr),
    .rom_rden     (rom_rden),
    .rom_q        (rom_q)
  );

  // 10-unit clock; a cycle counter numbers the period following each posedge
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM contents: word 2 holds a real instruction, others a recognisable pattern
  function automatic logic [31:0] rom_word(input logic [13:0] a);
    if (a == 14'd2) return 32'h0050_0093;
    return 32'h1300_0000 | {18'd0, a};
  endfunction

  // Memory models with one-cycle registered reads
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
    if (ram_rden) ram_q <= ram_mem[ram_addr];
    if (rom_rden) rom_q <= rom_word(rom_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Main-side monitor: counts beats/busy cycles and scores each done pulse
  int          m_beats = 0;
  int          m_busy = 0;
  logic [15:0] m_addr = '0;
  always @(negedge clk) begin
    main_exp_t e;
    string     n;
    if (!rst_n) begin
      m_beats = 0;
      m_busy  = 0;
    end else begin
      checkOutput("strobe_overlap", {31'd0, ram_rden & ram_wren}, 32'd0);
      if (ram_rden || ram_wren) begin
        if (m_beats == 0) m_addr = ram_addr;
        m_beats++;
      end
      if (busy_main) m_busy++;
      if (done_main) begin
        if (main_q.size() == 0) begin
          checkOutput("unexpected_done", {31'd0, done_main}, 32'd0);
        end else begin
          e = main_q.pop_front();
          n = main_names.pop_front();
          checkOutput({n, "_cycle"}, 32'(cyc), 32'(e.exp_cyc));
          checkOutput({n, "_err"}, {31'd0, err_main}, {31'd0, e.exp_err});
          checkOutput({n, "_rdata"}, rdata, e.exp_data);
          checkOutput({n, "_beats"}, 32'(m_beats), 32'(e.exp_beats));
          checkOutput({n, "_busy"}, 32'(m_busy), 32'(e.exp_busy));
          if (e.exp_beats != 0) checkOutput({n, "_addr"}, {16'd0, m_addr}, {16'd0, e.exp_addr});
        end
        m_beats = 0;
        m_busy  = 0;
      end else if (err_main) begin
        checkOutput("err_without_done", {31'd0, err_main}, 32'd0);
      end
    end
  end

  // Fetch-side monitor
  int          f_rden = 0;
  int          f_busy = 0;
  logic [13:0] f_addr = '0;
  always @(negedge clk) begin
    fetch_exp_t e;
    string      n;
    if (!rst_n) begin
      f_rden = 0;
      f_busy = 0;
    end else begin
      if (rom_rden) begin
        f_addr = rom_addr;
        f_rden++;
      end
      if (busy_fetch) f_busy++;
      if (fetch_valid) begin
        if (fetch_q.size() == 0) begin
          checkOutput("unexpected_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        end else begin
          e = fetch_q.pop_front();
          n = fetch_names.pop_front();
          checkOutput({n, "_cycle"}, 32'(cyc), 32'(e.exp_cyc));
          checkOutput({n, "_err"}, {31'd0, fetch_err}, {31'd0, e.exp_err});
          checkOutput({n, "_data"}, fetch_data, e.exp_data);
          checkOutput({n, "_rden"}, 32'(f_rden), e.exp_err ? 32'd0 : 32'd1);
          checkOutput({n, "_busy"}, 32'(f_busy), e.exp_err ? 32'd0 : 32'd2);
          if (!e.exp_err) checkOutput({n, "_romaddr"}, {18'd0, f_addr}, {18'd0, e.exp_addr});
        end
        f_rden = 0;
        f_busy = 0;
      end
    end
  end

  task automatic start_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive a load/store for the coming edge and push its expected response
  task automatic queue_main(input string name, input bit rd, input bit wr,
                            input logic [31:0] addr, input logic [1:0] width,
                            input bit uns, input logic [31:0] wdata,
                            input bit err, input logic [31:0] load_val,
                            input bit expect_done);
    main_exp_t   e;
    int          n;
    logic [31:0] off;
    req_read     = rd;
    req_write    = wr;
    req_addr     = addr;
    req_width    = width;
    req_unsigned = uns;
    req_wdata    = wdata;
    n   = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
    off = addr - 32'hC000_0000;
    e.exp_err   = err;
    e.exp_beats = err ? 0 : n;
    if (err)     e.exp_cyc = cyc + 1;
    else if (rd) e.exp_cyc = cyc + n + 2;
    else         e.exp_cyc = cyc + n + 1;
    e.exp_busy = err ? 0 : e.exp_cyc - cyc - 1;
    e.exp_addr = off[15:0];
    if (!err && rd) last_rdata = load_val;
    e.exp_data = last_rdata;
    if (expect_done) begin
      main_q.push_back(e);
      main_names.push_back(name);
    end
  endtask

  task automatic queue_fetch(input string name, input logic [31:0] addr,
                             input bit err, input logic [31:0] data);
    fetch_exp_t  e;
    logic [31:0] off;
    fetch_req  = 1'b1;
    fetch_addr = addr;
    off = addr - 32'h8000_0000;
    if (!err) last_fetch = data;
    e.exp_err  = err;
    e.exp_cyc  = cyc + (err ? 1 : 3);
    e.exp_data = last_fetch;
    e.exp_addr = off[15:2];
    fetch_q.push_back(e);
    fetch_names.push_back(name);
  endtask

  // Let the accept edge pass, then withdraw all request levels
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    req_read  = 1'b0;
    req_write = 1'b0;
    fetch_req = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((main_q.size() != 0 || fetch_q.size() != 0) && k < 40) begin
      @(posedge clk);
      k++;
    end
    checkOutput("pending_responses", 32'(main_q.size() + fetch_q.size()), 32'd0);
    main_q.delete();
    main_names.delete();
    fetch_q.delete();
    fetch_names.delete();
    @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_rdata"}, rdata, 32'd0);
    checkOutput({tag, "_main_flags"}, {29'd0, busy_main, done_main, err_main}, 32'd0);
    checkOutput({tag, "_ram_strobes"}, {30'd0, ram_rden, ram_wren}, 32'd0);
    checkOutput({tag, "_ram_bus"}, {8'd0, ram_addr, ram_wdata}, 32'd0);
    checkOutput({tag, "_fetch_data"}, fetch_data, 32'd0);
    checkOutput({tag, "_fetch_flags"}, {28'd0, fetch_valid, fetch_err, busy_fetch, rom_rden}, 32'd0);
    checkOutput({tag, "_rom_addr"}, {18'd0, rom_addr}, 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    req_read     = 1'b0;
    req_write    = 1'b0;
    req_addr     = 32'd0;
    req_width    = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 32'd0;
    fetch_req    = 1'b0;
    fetch_addr   = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Word store, then byte-level RAM contents
    start_cycle();
    queue_main("st_word", 0, 1, 32'hC000_0010, 2'd2, 0, 32'hDEAD_BEEF, 0, 32'd0, 1);
    applyStimulus();
    wait_idle();
    checkOutput("ram_10", {24'd0, ram_mem[16'h0010]}, 32'h0000_00EF);
    checkOutput("ram_11", {24'd0, ram_mem[16'h0011]}, 32'h0000_00BE);
    checkOutput("ram_12", {24'd0, ram_mem[16'h0012]}, 32'h0000_00AD);
    checkOutput("ram_13", {24'd0, ram_mem[16'h0013]}, 32'h0000_00DE);

    // Loads of assorted widths and extensions, plus rejected accesses
    start_cycle(); queue_main("ld_byte_s", 1, 0, 32'hC000_0013, 2'd0, 0, 0, 0, 32'hFFFF_FFDE, 1); applyStimulus(); wait_idle();
    start_cycle(); queue_main("ld_byte_u", 1, 0, 32'hC000_0013, 2'd0, 1, 0, 0, 32'h0000_00DE, 1); applyStimulus(); wait_idle();
    start_cycle(); queue_main("ld_half_misal", 1, 0, 32'hC000_0011, 2'd1, 0, 0, 1, 32'd0, 1); applyStimulus(); wait_idle();
    start_cycle(); queue_main("ld_word_oob", 1, 0, 32'hC000_FFFE, 2'd2, 0, 0, 1, 32'd0, 1); applyStimulus(); wait_idle();
    start_cycle(); queue_main("ld_half_s", 1, 0, 32'hC000_0012, 2'd1, 0, 0, 0, 32'hFFFF_DEAD, 1); applyStimulus(); wait_idle();
    start_cycle(); queue_main("ld_half_u", 1, 0, 32'hC000_0010, 2'd1, 1, 0, 0, 32'h0000_BEEF, 1); applyStimulus(); wait_idle();
    start_cycle(); queue_main("ld_word", 1, 0, 32'hC000_0010, 2'd2, 0, 0, 0, 32'hDEAD_BEEF, 1); applyStimulus(); wait_idle();

    // Top-of-RAM boundary and other rejected forms
    start_cycle(); queue_main("st_byte_top", 0, 1, 32'hC000_FFFF, 2'd0, 0, 32'h1234_5680, 0, 32'd0, 1); applyStimulus(); wait_idle();
    start_cycle(); queue_main("ld_byte_top_s", 1, 0, 32'hC000_FFFF, 2'd0, 0, 0, 0, 32'hFFFF_FF80, 1); applyStimulus(); wait_idle();
    start_cycle(); queue_main("ld_byte_top_u", 1, 0, 32'hC000_FFFF, 2'd0, 1, 0, 0, 32'h0000_0080, 1); applyStimulus(); wait_idle();
    start_cycle(); queue_main("ld_word_last", 1, 0, 32'hC000_FFFC, 2'd2, 0, 0, 0, 32'h8000_0000, 1); applyStimulus(); wait_idle();
    start_cycle(); queue_main("width3", 1, 0, 32'hC000_0010, 2'd3, 0, 0, 1, 32'd0, 1); applyStimulus(); wait_idle();
    start_cycle(); queue_main("rd_and_wr", 1, 1, 32'hC000_0010, 2'd2, 0, 0, 1, 32'd0, 1); applyStimulus(); wait_idle();
    start_cycle(); queue_main("st_word_past", 0, 1, 32'hC001_0000, 2'd2, 0, 32'h5555_5555, 1, 32'd0, 1); applyStimulus(); wait_idle();
    start_cycle(); queue_main("ld_below_base", 1, 0, 32'hBFFF_FFFF, 2'd0, 0, 0, 1, 32'd0, 1); applyStimulus(); wait_idle();
    checkOutput("ram_past_untouched", {24'd0, ram_mem[16'h0000]}, 32'd0);

    // Fetch path
    start_cycle(); queue_fetch("fetch_w2", 32'h8000_0008, 0, 32'h0050_0093); applyStimulus(); wait_idle();
    start_cycle(); queue_fetch("fetch_misal", 32'h8000_0002, 1, 32'd0); applyStimulus(); wait_idle();
    start_cycle(); queue_fetch("fetch_last", 32'h8000_FFFC, 0, 32'h1300_3FFF); applyStimulus(); wait_idle();
    start_cycle(); queue_fetch("fetch_oob", 32'h8001_0000, 1, 32'd0); applyStimulus(); wait_idle();

    // Concurrent word load and fetch issued on the same edge
    start_cycle();
    queue_main("cc_ld_word", 1, 0, 32'hC000_0010, 2'd2, 0, 0, 0, 32'hDEAD_BEEF, 1);
    queue_fetch("cc_fetch", 32'h8000_000C, 0, 32'h1300_0003);
    applyStimulus();
    wait_idle();

    // Reset during cycle 2 of a word store
    start_cycle();
    queue_main("rst_store", 0, 1, 32'hC000_0020, 2'd2, 0, 32'h1122_3344, 0, 32'd0, 0);
    applyStimulus();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("mid_reset");
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    last_rdata = 32'd0;
    last_fetch = 32'd0;
    checkOutput("partial_20", {24'd0, ram_mem[16'h0020]}, 32'h0000_0044);
    checkOutput("partial_21", {24'd0, ram_mem[16'h0021]}, 32'h0000_0033);
    checkOutput("partial_22", {24'd0, ram_mem[16'h0022]}, 32'h0000_0000);
    checkOutput("partial_23", {24'd0, ram_mem[16'h0023]}, 32'h0000_0000);
    repeat (2) @(posedge clk);
    start_cycle(); queue_main("ld_after_rst", 1, 0, 32'hC000_0020, 2'd2, 0, 0, 0, 32'h0000_3344, 1); applyStimulus(); wait_idle();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
